// File: rtl/dispensador_vuelto.sv
// rtl/dispensador_vuelto.sv - change dispenser: greedy 500/100 coin ejection with ack handshake and timeout
module dispensador_vuelto #(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk_50Mhz,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] credito,
  input  logic [4:0] precio,
  input  logic       ack,
  output logic       eject_q,
  output logic       eject_c,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [6:0] hex1,
  output logic [6:0] hex2
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CALC, EJECT_Q, RELEASE_Q, EJECT_C, RELEASE_C, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      cred_q, cred_d, prec_q, prec_d, cambio_q, cambio_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            error_q, error_d;
  logic            eject_q_q, eject_c_q, busy_q, done_q;
  logic [6:0]      hex1_q, hex2_q;
  logic            timed_out;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  // cnt_d defaults to zero so every state change restarts the wait budget
  always_comb begin
    state_d  = state_q;
    cred_d   = cred_q;
    prec_d   = prec_q;
    cambio_d = cambio_q;
    error_d  = error_q;
    cnt_d    = '0;
    case (state_q)
      IDLE: begin
        cambio_d = '0;
        if (start) begin
          cred_d  = credito;
          prec_d  = precio;
          error_d = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cred_q < prec_q) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          cambio_d = cred_q - prec_q;
          if (cambio_d >= 5'd5)      state_d = EJECT_Q;
          else if (cambio_d != 5'd0) state_d = EJECT_C;
          else                       state_d = DONE;
        end
      end
      EJECT_Q, EJECT_C: begin
        if (ack) begin
          cambio_d = cambio_q - ((state_q == EJECT_Q) ? 5'd5 : 5'd1);
          state_d  = (state_q == EJECT_Q) ? RELEASE_Q : RELEASE_C;
        end else if (timed_out) begin
          error_d  = 1'b1;
          cambio_d = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE_Q, RELEASE_C: begin
        if (!ack) begin
          if (cambio_q >= 5'd5 && state_q == RELEASE_Q) state_d = EJECT_Q;
          else if (cambio_q != 5'd0)                    state_d = EJECT_C;
          else                                          state_d = DONE;
        end else if (timed_out) begin
          error_d  = 1'b1;
          cambio_d = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next state so they are flops aligned with the state
  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cred_q    <= '0;
      prec_q    <= '0;
      cambio_q  <= '0;
      cnt_q     <= '0;
      error_q   <= 1'b0;
      eject_q_q <= 1'b0;
      eject_c_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hex1_q    <= 7'b1000000;
      hex2_q    <= 7'b1000000;
    end else begin
      state_q   <= state_d;
      cred_q    <= cred_d;
      prec_q    <= prec_d;
      cambio_q  <= cambio_d;
      cnt_q     <= cnt_d;
      error_q   <= error_d;
      eject_q_q <= (state_d == EJECT_Q);
      eject_c_q <= (state_d == EJECT_C);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      hex1_q    <= seg7(4'(cambio_d / 5'd10));
      hex2_q    <= seg7(4'(cambio_d % 5'd10));
    end
  end

  assign eject_q = eject_q_q;
  assign eject_c = eject_c_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;
  assign hex1    = hex1_q;
  assign hex2    = hex2_q;

endmodule
